// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stage indices, stage vectors and sequencer states.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

package pipe_pkg;

   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;
   localparam int NUM_STG   = 5;

   typedef logic [NUM_STG-1:0] stage_vec_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } pctl_state_t;

   function automatic stage_vec_t stg_span(int lo, int hi);
      stage_vec_t v;
      v = '0;
      for (int i = 0; i < NUM_STG; i++) begin
         if (i >= lo && i <= hi) v[i] = 1'b1;
      end
      return v;
   endfunction

   // Bubble goes into the first register above a prefix-shaped stall.
   function automatic stage_vec_t bubble_after(stage_vec_t stall);
      return (stall + 1'b1) & ~stall & ~stg_span(STG_PC, STG_PC);
   endfunction

endpackage

// File: rtl/div_timer.sv
// Loadable down-counter that saturates at zero; tracks remaining divide cycles.
module div_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)                     cnt_d = load_val;
      else if (en && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline.
// Priority: exception > memory wait > divide > load-use > branch.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_load_use,
   input  logic                     id_br_taken,
   input  logic [`COMMON_WIDTH-1:0] id_br_target,
   input  logic                     ex_div_start,
   input  logic                     mem_req,
   input  logic                     mem_ack,
   input  logic                     exc_req,
   input  logic [`COMMON_WIDTH-1:0] exc_vector,
   output logic [4:0]               stall,
   output logic [4:0]               flush,
   output logic                     redirect_valid,
   output logic [`COMMON_WIDTH-1:0] redirect_pc,
   output logic                     div_busy,
   output logic                     div_done,
   output logic                     div_abort
);

   localparam stage_vec_t STALL_LU  = stg_span(STG_PC, STG_IFID);
   localparam stage_vec_t STALL_DIV = stg_span(STG_PC, STG_IDEX);
   localparam stage_vec_t STALL_MEM = stg_span(STG_PC, STG_EXMEM);
   localparam stage_vec_t FLUSH_EXC = stg_span(STG_IFID, STG_MEMWB);
   localparam stage_vec_t FLUSH_BR  = stg_span(STG_IFID, STG_IFID);

   pctl_state_t      state_q, state_d;
   logic             tmr_load, tmr_zero;
   logic [CNT_W-1:0] tmr_val, tmr_cnt;
   logic             mem_wait, run_eval, div_ok;
   logic             unused_cnt;

   div_timer #(.CNT_W(CNT_W)) u_div_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (1'b1),
      .cnt      (tmr_cnt),
      .zero     (tmr_zero)
   );

   // Only the zero flag steers the sequencer; the raw count is for observation.
   assign unused_cnt = ^tmr_cnt;
   assign mem_wait   = mem_req & ~mem_ack;

   always_comb begin
      state_d        = state_q;
      stall          = '0;
      flush          = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      div_busy       = 1'b0;
      div_done       = 1'b0;
      div_abort      = 1'b0;
      tmr_load       = 1'b0;
      tmr_val        = '0;
      run_eval       = 1'b0;
      div_ok         = 1'b0;

      if (exc_req) begin
         flush          = FLUSH_EXC;
         redirect_valid = 1'b1;
         redirect_pc    = exc_vector;
         div_abort      = (state_q == DIV_WAIT) | ex_div_start;
         div_busy       = (state_q == DIV_WAIT);
         state_d        = RUN;
         tmr_load       = 1'b1;
      end else if (mem_wait) begin
         stall    = STALL_MEM;
         flush    = bubble_after(STALL_MEM);
         div_busy = (state_q == DIV_WAIT);
         if (state_q == RUN) state_d = MEM_WAIT;
      end else begin
         unique case (state_q)
            RUN: begin
               run_eval = 1'b1;
               div_ok   = 1'b1;
            end
            MEM_WAIT: begin
               state_d  = RUN;
               run_eval = 1'b1;
               div_ok   = 1'b1;
            end
            DIV_WAIT: begin
               if (tmr_zero) begin
                  // EX still holds the finished divide, so it must not re-issue.
                  div_done = 1'b1;
                  state_d  = RUN;
                  run_eval = 1'b1;
               end else begin
                  stall    = STALL_DIV;
                  flush    = bubble_after(STALL_DIV);
                  div_busy = 1'b1;
               end
            end
            default: state_d = RUN;
         endcase

         if (run_eval) begin
            if (div_ok && ex_div_start) begin
               stall    = STALL_DIV;
               flush    = bubble_after(STALL_DIV);
               state_d  = DIV_WAIT;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(DIV_CYCLES - 2);
            end else if (id_load_use) begin
               stall = STALL_LU;
               flush = bubble_after(STALL_LU);
            end else if (id_br_taken) begin
               flush          = FLUSH_BR;
               redirect_valid = 1'b1;
               redirect_pc    = id_br_target;
            end
         end
      end

      if (rst) begin
         stall          = '0;
         flush          = '0;
         redirect_valid = 1'b0;
         redirect_pc    = '0;
         div_busy       = 1'b0;
         div_done       = 1'b0;
         div_abort      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage in-order pipeline.
- Drives the hold and bubble controls of the pc register and of the ifid, idex, exmem and memwb pipeline registers.
- Arbitrates four event sources: load-use hazards, taken branches, multi-cycle divides, and data-memory wait states.
- Also arbitrates exceptions, and produces a single prioritized PC redirect to the fetch stage.

Parameters:
- DIV_CYCLES, 32: total cycles a divide occupies EX, including the issue cycle. Legal range is 2 or more.
- CNT_W, $clog2(DIV_CYCLES): width of the divide cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_load_use  input  1  ID has detected a load-use hazard against the instruction in EX.
- id_br_taken  input  1  ID resolved a taken branch or jump.
- id_br_target  input  `COMMON_WIDTH  target of the taken branch.
- ex_div_start  input  1  EX holds a divide instruction; held asserted while EX is stalled.
- mem_req  input  1  MEM stage is performing a data-memory access.
- mem_ack  input  1  data memory completes the access this cycle.
- exc_req  input  1  MEM stage raises an exception.
- exc_vector  input  `COMMON_WIDTH  exception handler address.
- stall  output  5  hold enable per register. Bit 0 = pc, 1 = ifid, 2 = idex, 3 = exmem, 4 = memwb.
- flush  output  5  load-bubble enable per register, same indexing; bit 0 is always 0.
- redirect_valid  output  1  fetch takes redirect_pc on the next edge.
- redirect_pc  output  `COMMON_WIDTH  redirect address; 0 when redirect_valid = 0.
- div_busy  output  1  divider sequence in progress (state DIV_WAIT).
- div_done  output  1  one-cycle pulse; the divide result is valid in EX this cycle.
- div_abort  output  1  one-cycle pulse; the in-flight divide is cancelled.

Behaviour:
- State machine states: RUN, DIV_WAIT, MEM_WAIT. Counter: cnt[CNT_W-1:0].
- All outputs are combinational from the state, cnt and the inputs.
- While rst = 1: state = RUN, cnt = 0, and every output is 0, regardless of inputs.
- Stall vectors are always prefix-shaped: if stall[k] = 1, then stall[j] = 1 for all j < k.
- Whenever stall[k] = 1 and stall[k+1] = 0, flush[k+1] = 1 (a bubble enters the first running stage).
- Priority, highest first: exception, memory wait, divide, load-use, branch.

Exception (any state, exc_req = 1):
- stall = 00000, flush = 11110, redirect_valid = 1, redirect_pc = exc_vector.
- Next state = RUN, cnt <= 0.
- div_abort = 1 if and only if the current state is DIV_WAIT, or ex_div_start = 1.

Memory wait:
- Condition: mem_req = 1 and mem_ack = 0.
- Response: stall = 01111, flush = 10000.
- From RUN: next state = MEM_WAIT.
- In MEM_WAIT, the same outputs hold until mem_ack = 1.
- In the ack cycle the stall is released (normal RUN evaluation applies); next state = RUN.
- mem_req = 1 with mem_ack = 1 in the same cycle: no stall.

Divide, in RUN, when ex_div_start = 1 with no memory wait:
- Issue cycle: stall = 00111, flush = 01000, next state = DIV_WAIT, cnt <= DIV_CYCLES-2.
- DIV_WAIT: stall = 00111, flush = 01000, div_busy = 1. cnt decrements each cycle, saturating at 0.
- When cnt = 0 and there is no memory wait: div_done = 1, stall released, next state = RUN.
- Memory wait during DIV_WAIT:
  - stall = 01111, flush = 10000.
  - cnt keeps decrementing/saturating.
  - The exit (and div_done) is deferred until the memory wait clears.
- Result: the stall lasts exactly DIV_CYCLES-1 cycles when no other events occur.
- ex_div_start is ignored outside RUN.

Load-use, in RUN, with no higher-priority event:
- stall = 00011, flush = 00100. Single cycle per assertion.
- A taken branch in the same cycle is suppressed: redirect_valid = 0, and ID re-evaluates the branch next cycle.

Branch, in RUN, with no other event:
- redirect_valid = 1, redirect_pc = id_br_target, flush = 00010, stall = 00000.

Suppression outside RUN:
- id_br_taken and id_load_use are ignored in DIV_WAIT and MEM_WAIT. ID is held, so both re-present after release.

Reset mid-operation:
- Asserting rst in DIV_WAIT or MEM_WAIT returns to RUN immediately.
- No div_done or div_abort pulse is produced.

Decomposition:
- Shared package pipe_pkg:
  - stage index constants STG_PC, STG_IFID, STG_IDEX, STG_EXMEM, STG_MEMWB.
  - typedef stage_vec_t (5 bits).
  - enum pctl_state_t {RUN, DIV_WAIT, MEM_WAIT}.
- Sub-module div_timer: a loadable, saturating down-counter.
  - Inputs: load, load_val, en.
  - Outputs: cnt, zero.
- pipe_ctrl holds the state register, the priority logic and the stall/flush encoding.

Test Plan:
- Reset: assert rst with all inputs at 1 → every output 0. After release with idle inputs, stall = 0, flush = 0, redirect_valid = 0.
- Load-use plus branch: id_load_use = 1, id_br_taken = 1, target 0x100 for one cycle → stall = 00011, flush = 00100, redirect_valid = 0. Next cycle, branch only → redirect_pc = 0x100, flush = 00010.
- Divide: DIV_CYCLES = 4, pulse-hold ex_div_start → stall = 00111 for exactly 3 cycles, div_busy for 2 cycles, div_done on the 4th cycle, then RUN.
- Memory wait: mem_req = 1 with mem_ack low for 3 cycles, then high → stall = 01111 and flush = 10000 for 3 cycles, released in the ack cycle.
- Divide overlapped by memory wait: memory wait starts at cnt = 1, ack arrives 3 cycles later → div_done delayed to the ack cycle, with no early exit.
- Exception in DIV_WAIT: exc_req = 1, exc_vector = 0x80000180 → flush = 11110, redirect_pc = 0x80000180, div_abort = 1, next state RUN, with no div_done afterwards.
